vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator.
- Takes active-low hsync/vsync, measures the line and frame timing, and decides whether the timing is stable (lock).
- Once locked, recovers the pixel coordinates and data-enable for the 256x256 active window.
- Sits at the input of capture/checker logic. Runs on the same pixel clock as the source, but the sync inputs are still synchronized.

Parameters:
CW, 11, width of all measurement counters (max 2047)
HA_OFS, 144, clocks from hsync falling edge to first active pixel
HA_W, 256, active pixels per line
VA_OFS, 32, lines from vsync falling edge to first active line
VA_H, 256, active lines per frame
H_TOL, 1, allowed +/- deviation of line length, in clocks
LOCK_FRAMES, 2, consecutive matching frames required for lock

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
i_hs  in  1  horizontal sync, active low
i_vs  in  1  vertical sync, active low
o_locked  out  1  timing stable, coordinates valid
o_de  out  1  current pixel inside active window (locked only)
o_x  out  9  recovered x, 0..HA_W-1; 0 outside window
o_y  out  9  recovered y, 0..VA_H-1; 0 outside window
o_line_len  out  CW  last measured clocks per line
o_hs_width  out  CW  last measured hsync low width
o_frame_lines  out  CW  last measured lines per frame
o_vs_width  out  CW  last measured vsync low width, in lines

Behaviour:
- Reset clock and polarity:
  - Reset is synchronous, active-high, on clock clk.
  - While rst: all outputs 0, state SEARCH, counters and synchronizers 0, history cleared.
- Input path and edge events:
  - i_hs/i_vs pass through 2 flops, plus a 3rd delay flop for edge detect.
  - hs_fall = s2==0 && s3==1; hs_rise and vs_fall/vs_rise are defined the same way.
  - All outputs are aligned to the synchronized stream, 3 clocks after the input edge.
- Horizontal measurement:
  - h_cnt clears to 0 on hs_fall, otherwise increments, saturating at 2^CW-1.
  - On hs_fall: o_line_len <= h_cnt+1.
  - On hs_rise: o_hs_width <= h_cnt+1.
- Vertical measurement:
  - line_cnt clears on vs_fall and increments on each hs_fall, saturating.
  - On vs_fall: o_frame_lines <= line_cnt (plus 1 if hs_fall in the same cycle).
  - On vs_rise: o_vs_width <= lines counted since vs_fall.
- Timeout: h_cnt saturated, or line_cnt saturated -> measurement invalid -> state SEARCH, o_locked=0.
- FSM states: SEARCH, MEASURE, LOCKED.
  - SEARCH: on first vs_fall -> MEASURE; store ref_len=o_line_len, ref_lines=0 (invalid); match_cnt=0.
  - MEASURE, on each vs_fall:
    - Match = frame lines == ref_lines AND |line_len - ref_len| <= H_TOL.
    - Match -> match_cnt++; when match_cnt reaches LOCK_FRAMES-1 on a match -> LOCKED.
    - Mismatch -> match_cnt=0, stay in MEASURE.
    - Either way, ref values update to the current frame.
  - LOCKED:
    - Any hs_fall with line length outside ref_len +/- H_TOL -> SEARCH.
    - Any vs_fall with frame lines != ref_lines -> SEARCH.
    - Timeout -> SEARCH.
  - o_locked = (state==LOCKED), registered; it drops the cycle after the faulty event is detected.
- Coordinate recovery, registered:
  - de_h = h_cnt in [HA_OFS, HA_OFS+HA_W).
  - de_v = line_cnt in [VA_OFS, VA_OFS+VA_H).
  - o_de = locked && de_h && de_v.
  - o_x = o_de ? h_cnt-HA_OFS : 0; o_y = o_de ? line_cnt-VA_OFS : 0, truncated to 9 bits.
- Simultaneous hs_fall and vs_fall: line_cnt=0 and h_cnt=0 in the same cycle. The frame count includes that line.
- Mid-operation reset: state is lost immediately. Relock requires 1 + LOCK_FRAMES vs_falls.
- A sync pulse asserted at reset release is not counted as a falling edge.

Test Plan:
- Reference generator timing (801-clock lines, hs low 96, 522-line frames, vs low 2) for 4 frames:
  - -> o_line_len=801, o_hs_width=96, o_frame_lines=522, o_vs_width=2.
  - -> o_locked rises after the 3rd vs_fall.
- Locked stream, observe one frame:
  - -> o_de high exactly 256 clocks/line for 256 lines.
  - -> first active pixel: o_x=0,o_y=0 at h_cnt=144, line 32.
  - -> last active pixel: o_x=255,o_y=255.
- Locked, then one line shortened to 799 clocks:
  - -> o_locked=0 one cycle after that hs_fall.
  - -> relock after 3 clean frames.
- Line jitter of 800/801/802 alternating with H_TOL=1 around 801:
  - -> lock held.
- Change to 803 clocks:
  - -> lock lost.
- Hold i_hs high for 2100 clocks:
  - -> timeout, o_locked=0, o_de=0.
  - -> SEARCH until the next vs_fall.
- Assert rst mid-frame while locked:
  - -> all outputs 0 next cycle.
  - -> after release, lock only after 3 further vs_falls.

Source files
------------

// File: rtl/vga_sync_decoder_if.sv
// rtl/vga_sync_decoder_if.sv - sync inputs and recovered timing outputs of the VGA sync decoder
// master drives the syncs (source side), slave is the decoder.
interface vga_sync_decoder_if #(
  parameter int CW = 11
);
  logic          i_hs;
  logic          i_vs;
  logic          o_locked;
  logic          o_de;
  logic [8:0]    o_x;
  logic [8:0]    o_y;
  logic [CW-1:0] o_line_len;
  logic [CW-1:0] o_hs_width;
  logic [CW-1:0] o_frame_lines;
  logic [CW-1:0] o_vs_width;

  modport master (
    output i_hs, i_vs,
    input  o_locked, o_de, o_x, o_y, o_line_len, o_hs_width, o_frame_lines, o_vs_width
  );

  modport slave (
    input  i_hs, i_vs,
    output o_locked, o_de, o_x, o_y, o_line_len, o_hs_width, o_frame_lines, o_vs_width
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - measures hsync/vsync timing, locks on stable frames, recovers x/y/de
// All measurements run on the synchronized stream, three clocks behind the pins.
module vga_sync_decoder #(
  parameter int CW          = 11,
  parameter int HA_OFS      = 144,
  parameter int HA_W        = 256,
  parameter int VA_OFS      = 32,
  parameter int VA_H        = 256,
  parameter int H_TOL       = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_decoder_if.slave bus
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state, state_nxt;
  logic          hs_s1, hs_s2, hs_s3;
  logic          vs_s1, vs_s2, vs_s3;
  logic          hs_fall, hs_rise, vs_fall, vs_rise;
  logic [CW-1:0] h_cnt, line_cnt;
  logic [CW-1:0] h_inc, line_inc, h_nxt, line_nxt;
  logic [CW-1:0] cur_len, cur_lines, len_diff;
  logic [CW-1:0] ref_len, ref_lines;
  logic [CW-1:0] x_full, y_full;
  logic [7:0]    match_cnt;
  logic          len_ok, frame_match, lock_ready, timeout;
  logic          de_h, de_v;

  always_comb begin
    hs_fall   = !hs_s2 && hs_s3;
    hs_rise   = hs_s2 && !hs_s3;
    vs_fall   = !vs_s2 && vs_s3;
    vs_rise   = vs_s2 && !vs_s3;
    h_inc     = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 1'b1;
    line_inc  = (line_cnt == CNT_MAX) ? CNT_MAX : line_cnt + 1'b1;
    h_nxt     = hs_fall ? '0 : h_inc;
    line_nxt  = vs_fall ? '0 : (hs_fall ? line_inc : line_cnt);
    // A line ending in this very cycle belongs to the measurement being taken now.
    cur_len   = hs_fall ? h_inc : bus.o_line_len;
    cur_lines = hs_fall ? line_inc : line_cnt;
    len_diff  = (cur_len > ref_len) ? cur_len - ref_len : ref_len - cur_len;
    len_ok    = len_diff <= CW'(H_TOL);
    frame_match = (cur_lines == ref_lines) && len_ok;
    lock_ready  = (int'(match_cnt) + 1) >= (LOCK_FRAMES - 1);
    // A saturated counter that an edge is clearing this cycle is not a stall.
    timeout   = ((h_cnt == CNT_MAX) && !hs_fall) || ((line_cnt == CNT_MAX) && !vs_fall);
    de_h      = (h_nxt >= CW'(HA_OFS)) && (h_nxt < CW'(HA_OFS + HA_W));
    de_v      = (line_nxt >= CW'(VA_OFS)) && (line_nxt < CW'(VA_OFS + VA_H));
    x_full    = h_nxt - CW'(HA_OFS);
    y_full    = line_nxt - CW'(VA_OFS);

    state_nxt = state;
    if (timeout) begin
      state_nxt = SEARCH;
    end else begin
      case (state)
        SEARCH:  if (vs_fall) state_nxt = MEASURE;
        MEASURE: if (vs_fall && frame_match && lock_ready) state_nxt = LOCKED;
        LOCKED:  if ((hs_fall && !len_ok) || (vs_fall && (cur_lines != ref_lines)))
                   state_nxt = SEARCH;
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= SEARCH;
      {hs_s1, hs_s2, hs_s3} <= '0;
      {vs_s1, vs_s2, vs_s3} <= '0;
      h_cnt             <= '0;
      line_cnt          <= '0;
      ref_len           <= '0;
      ref_lines         <= '0;
      match_cnt         <= '0;
      bus.o_locked      <= 1'b0;
      bus.o_de          <= 1'b0;
      bus.o_x           <= '0;
      bus.o_y           <= '0;
      bus.o_line_len    <= '0;
      bus.o_hs_width    <= '0;
      bus.o_frame_lines <= '0;
      bus.o_vs_width    <= '0;
    end else begin
      hs_s1    <= bus.i_hs;
      hs_s2    <= hs_s1;
      hs_s3    <= hs_s2;
      vs_s1    <= bus.i_vs;
      vs_s2    <= vs_s1;
      vs_s3    <= vs_s2;
      h_cnt    <= h_nxt;
      line_cnt <= line_nxt;
      state    <= state_nxt;

      if (hs_fall) bus.o_line_len    <= h_inc;
      if (hs_rise) bus.o_hs_width    <= h_inc;
      if (vs_fall) bus.o_frame_lines <= cur_lines;
      if (vs_rise) bus.o_vs_width    <= cur_lines;

      // The first frame after SEARCH has no usable line count, so it can never match.
      if (vs_fall && !timeout) begin
        if (state == SEARCH) begin
          ref_len   <= cur_len;
          ref_lines <= '0;
          match_cnt <= '0;
        end else if (state == MEASURE) begin
          ref_len   <= cur_len;
          ref_lines <= cur_lines;
          match_cnt <= frame_match ? match_cnt + 1'b1 : '0;
        end
      end

      bus.o_locked <= (state_nxt == LOCKED);
      bus.o_de     <= (state_nxt == LOCKED) && de_h && de_v;
      bus.o_x      <= ((state_nxt == LOCKED) && de_h && de_v) ? x_full[8:0] : '0;
      bus.o_y      <= ((state_nxt == LOCKED) && de_h && de_v) ? y_full[8:0] : '0;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - frame-table and corner-sequence bench for vga_sync_decoder
// Scaled-down geometry keeps the run short; CW stays 11 so the timeout is real.
module tb_vga_sync_decoder;

  localparam int CW     = 11;
  localparam int LEN    = 60;
  localparam int HSW    = 8;
  localparam int LINES  = 30;
  localparam int VSW    = 2;
  localparam int HA_OFS = 14;
  localparam int HA_W   = 40;
  localparam int VA_OFS = 4;
  localparam int VA_H   = 20;
  localparam int PIPE   = 3;

  typedef struct {
    int p0, p1, p2;
    int short_idx;
    bit exp_locked;
    int exp_len;
    int exp_drop_l;
    int exp_drop_c;
    bit chk_pix;
  } frame_vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_sync_decoder_if #(.CW(CW)) bus ();

  vga_sync_decoder #(
    .CW(CW), .HA_OFS(HA_OFS), .HA_W(HA_W), .VA_OFS(VA_OFS), .VA_H(VA_H),
    .H_TOL(1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  frame_vec_t vecs [14];
  int checks = 0;
  int errors = 0;
  int cur_l, cur_c;
  bit pix_en, prev_locked;
  int pix_bad, de_cnt, first_l, first_c, first_x, first_y, last_x, last_y;
  int drop_l, drop_c;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_stats(input bit en);
    pix_en = en; pix_bad = 0; de_cnt = 0;
    first_l = -1; first_c = -1; first_x = -1; first_y = -1;
    last_x = -1; last_y = -1; drop_l = -1; drop_c = -1;
  endtask

  // Sampled before the new drive: reflects the posedge just before this negedge.
  task automatic sample();
    int ex, ey;
    bit exp_de;
    if (pix_en) begin
      ex = cur_c - (HA_OFS + PIPE);
      ey = cur_l - VA_OFS;
      exp_de = (ex >= 0) && (ex < HA_W) && (ey >= 0) && (ey < VA_H);
      if ((bus.o_de != exp_de) || (int'(bus.o_x) != (exp_de ? ex : 0)) ||
          (int'(bus.o_y) != (exp_de ? ey : 0)))
        pix_bad++;
      if (bus.o_de) begin
        de_cnt++;
        if (first_l < 0) begin
          first_l = cur_l; first_c = cur_c;
          first_x = int'(bus.o_x); first_y = int'(bus.o_y);
        end
        last_x = int'(bus.o_x); last_y = int'(bus.o_y);
      end
    end
    if (prev_locked && !bus.o_locked && (drop_l < 0)) begin
      drop_l = cur_l; drop_c = cur_c;
    end
    prev_locked = bus.o_locked;
  endtask

  task automatic tick(input logic hs, input logic vs);
    @(negedge clk);
    sample();
    bus.i_hs = hs;
    bus.i_vs = vs;
  endtask

  task automatic send_line(input int len, input int l);
    for (int c = 0; c < len; c++) begin
      cur_l = l; cur_c = c;
      tick(c >= HSW, l >= VSW);
    end
  endtask

  task automatic send_frame(input int p0, input int p1, input int p2, input int short_idx);
    int pat [3];
    pat[0] = p0; pat[1] = p1; pat[2] = p2;
    for (int l = 0; l < LINES; l++)
      send_line((l == short_idx) ? LEN - 2 : pat[l % 3], l);
  endtask

  task automatic idle(input int n, input logic hs, input logic vs);
    for (int k = 0; k < n; k++) begin
      cur_l = -3; cur_c = k;
      tick(hs, vs);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, bus.o_locked, 0);
    check({tag, "_de"}, bus.o_de, 0);
    check({tag, "_x"}, int'(bus.o_x), 0);
    check({tag, "_y"}, int'(bus.o_y), 0);
    check({tag, "_line_len"}, int'(bus.o_line_len), 0);
    check({tag, "_hs_width"}, int'(bus.o_hs_width), 0);
    check({tag, "_frame_lines"}, int'(bus.o_frame_lines), 0);
    check({tag, "_vs_width"}, int'(bus.o_vs_width), 0);
  endtask

  task automatic check_pix(input string tag);
    check({tag, "_pix_bad"}, pix_bad, 0);
    check({tag, "_de_cnt"}, de_cnt, HA_W * VA_H);
    check({tag, "_first_line"}, first_l, VA_OFS);
    check({tag, "_first_col"}, first_c, HA_OFS + PIPE);
    check({tag, "_first_x"}, first_x, 0);
    check({tag, "_first_y"}, first_y, 0);
    check({tag, "_last_x"}, last_x, HA_W - 1);
    check({tag, "_last_y"}, last_y, VA_H - 1);
  endtask

  initial begin
    // p0 p1 p2 short locked len drop_l drop_c pix
    vecs[0]  = '{60, 60, 60, -1, 1'b0, 60, -1, -1, 1'b0};
    vecs[1]  = '{60, 60, 60, -1, 1'b0, 60, -1, -1, 1'b0};
    vecs[2]  = '{60, 60, 60, -1, 1'b1, 60, -1, -1, 1'b0};
    vecs[3]  = '{60, 60, 60, -1, 1'b1, 60, -1, -1, 1'b1};
    vecs[4]  = '{60, 60, 60, 10, 1'b0, 60, 11,  3, 1'b0};
    vecs[5]  = '{60, 60, 60, -1, 1'b0, 60, -1, -1, 1'b0};
    vecs[6]  = '{60, 60, 60, -1, 1'b0, 60, -1, -1, 1'b0};
    vecs[7]  = '{60, 60, 60, -1, 1'b1, 60, -1, -1, 1'b1};
    vecs[8]  = '{59, 60, 61, -1, 1'b1, 60, -1, -1, 1'b0};
    vecs[9]  = '{59, 60, 61, -1, 1'b1, 60, -1, -1, 1'b1};
    vecs[10] = '{62, 62, 62, -1, 1'b0, 62,  1,  3, 1'b0};
    vecs[11] = '{60, 60, 60, -1, 1'b0, 60, -1, -1, 1'b0};
    vecs[12] = '{60, 60, 60, -1, 1'b0, 60, -1, -1, 1'b0};
    vecs[13] = '{60, 60, 60, -1, 1'b1, 60, -1, -1, 1'b0};

    rst = 1'b1; bus.i_hs = 1'b1; bus.i_vs = 1'b1;
    prev_locked = 1'b0; cur_l = 0; cur_c = 0;
    start_stats(1'b0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    idle(20, 1'b1, 1'b1);

    for (int i = 0; i < 14; i++) begin
      start_stats(vecs[i].chk_pix);
      send_frame(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].short_idx);
      check($sformatf("f%0d_locked", i), bus.o_locked, vecs[i].exp_locked);
      check($sformatf("f%0d_line_len", i), int'(bus.o_line_len), vecs[i].exp_len);
      check($sformatf("f%0d_hs_width", i), int'(bus.o_hs_width), HSW);
      check($sformatf("f%0d_vs_width", i), int'(bus.o_vs_width), VSW);
      if (i > 0) check($sformatf("f%0d_frame_lines", i), int'(bus.o_frame_lines), LINES);
      check($sformatf("f%0d_drop_line", i), drop_l, vecs[i].exp_drop_l);
      check($sformatf("f%0d_drop_col", i), drop_c, vecs[i].exp_drop_c);
      if (vecs[i].chk_pix) check_pix($sformatf("f%0d", i));
    end

    // hsync stuck high: h_cnt saturates at 2047 and the lock must fall.
    start_stats(1'b0);
    for (int k = 0; k < 2100; k++) begin
      cur_l = -2; cur_c = k;
      tick(1'b1, 1'b1);
    end
    check("timeout_drop_col", drop_c, 1991);
    check("timeout_locked", bus.o_locked, 0);
    check("timeout_de", bus.o_de, 0);
    check("timeout_x", int'(bus.o_x), 0);
    check("timeout_y", int'(bus.o_y), 0);

    for (int r = 0; r < 3; r++) begin
      start_stats(1'b0);
      send_frame(LEN, LEN, LEN, -1);
      check($sformatf("relock%0d_locked", r), bus.o_locked, (r == 2) ? 1 : 0);
    end

    // Reset mid-frame with both syncs low across the release.
    start_stats(1'b0);
    for (int l = 0; l < 10; l++) send_line(LEN, l);
    check("pre_rst_locked", bus.o_locked, 1);
    @(negedge clk);
    rst = 1'b1; bus.i_hs = 1'b0; bus.i_vs = 1'b0;
    @(negedge clk);
    check_zero("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    prev_locked = 1'b0;
    idle(5, 1'b0, 1'b0);
    idle(20, 1'b1, 1'b1);
    for (int q = 0; q < 3; q++) begin
      start_stats(1'b0);
      send_frame(LEN, LEN, LEN, -1);
      check($sformatf("post_rst%0d_locked", q), bus.o_locked, (q == 2) ? 1 : 0);
    end
    check("post_rst_frame_lines", int'(bus.o_frame_lines), LINES);
    check("post_rst_line_len", int'(bus.o_line_len), LEN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
